// File: rtl/sd_fb_pkg.sv
// Shared types and default geometry for the RGB frame-buffer write and read sides.
package sd_fb_pkg;

  localparam int unsigned DEF_IMG_W  = 320;
  localparam int unsigned DEF_IMG_H  = 240;
  localparam int unsigned DEF_ADDR_W = 17;

  typedef enum logic [1:0] {S_HDR, S_PIX, S_DONE} fbw_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/sd_rgb_assembler.sv
// Packs an R,G,B byte stream into 24-bit pixels.
// The third byte is forwarded combinationally, so the caller registers the pixel.
module sd_rgb_assembler
  import sd_fb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_clear,
  input  logic       i_en,
  input  logic [7:0] i_byte,
  output logic       o_pix_valid,
  output rgb_t       o_pix
);

  logic [1:0] r_phase;
  logic [7:0] r_r;
  logic [7:0] r_g;

  // Track byte phase within a pixel and latch the first two colour bytes.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_phase <= 2'd0;
      r_r     <= 8'd0;
      r_g     <= 8'd0;
    end else if (i_clear) begin
      r_phase <= 2'd0;
    end else if (i_en) begin
      unique case (r_phase)
        2'd0: begin
          r_r     <= i_byte;
          r_phase <= 2'd1;
        end
        2'd1: begin
          r_g     <= i_byte;
          r_phase <= 2'd2;
        end
        default: r_phase <= 2'd0;
      endcase
    end
  end

  assign o_pix_valid = i_en && (r_phase == 2'd2);
  assign o_pix       = '{r: r_r, g: r_g, b: i_byte};

endmodule

// File: rtl/sd_rgb_fb_writer.sv
// Writes a raw .RGB byte stream into the frame-buffer BRAM, one write per pixel,
// after skipping a fixed file header. Flags frame completion and overrun.
module sd_rgb_fb_writer
  import sd_fb_pkg::*;
#(
  parameter int unsigned IMG_W     = DEF_IMG_W,
  parameter int unsigned IMG_H     = DEF_IMG_H,
  parameter int unsigned HDR_BYTES = 0,
  parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_clear,
  input  logic                       i_in_en,
  input  logic [7:0]                 i_in_byte,
  output logic                       o_fb_we,
  output logic [ADDR_W-1:0]          o_fb_addr,
  output logic [23:0]                o_fb_wdata,
  output logic [$clog2(IMG_W)-1:0]   o_cur_x,
  output logic [$clog2(IMG_H)-1:0]   o_cur_y,
  output logic                       o_frame_done,
  output logic                       o_overflow
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam int unsigned HW = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;

  localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
  localparam logic [HW-1:0] HDR_LAST = HW'((HDR_BYTES > 0) ? HDR_BYTES - 1 : 0);
  localparam fbw_state_t    S_INIT   = (HDR_BYTES > 0) ? S_HDR : S_PIX;

  fbw_state_t        r_state, w_state_d;
  logic [HW-1:0]     r_hdr, w_hdr_d;
  logic [XW-1:0]     r_x, w_x_d;
  logic [YW-1:0]     r_y, w_y_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic              r_we, w_we_d;
  logic [ADDR_W-1:0] r_fb_addr, w_fb_addr_d;
  logic [23:0]       r_wdata, w_wdata_d;
  logic              r_done, w_done_d;
  logic              r_ovf, w_ovf_d;

  logic w_asm_en;
  logic w_pix_valid;
  rgb_t w_pix;

  // A clear in the same cycle as a byte drops that byte.
  assign w_asm_en = i_in_en && !i_clear && (r_state == S_PIX);

  sd_rgb_assembler u_asm (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_clear     (i_clear),
    .i_en        (w_asm_en),
    .i_byte      (i_in_byte),
    .o_pix_valid (w_pix_valid),
    .o_pix       (w_pix)
  );

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= S_INIT;
      r_hdr     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_fb_addr <= '0;
      r_wdata   <= '0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_hdr     <= w_hdr_d;
      r_x       <= w_x_d;
      r_y       <= w_y_d;
      r_addr    <= w_addr_d;
      r_we      <= w_we_d;
      r_fb_addr <= w_fb_addr_d;
      r_wdata   <= w_wdata_d;
      r_done    <= w_done_d;
      r_ovf     <= w_ovf_d;
    end
  end

  // Next-state: header skip, pixel write with x/y/address stepping, done/overflow flags.
  always_comb begin
    w_state_d   = r_state;
    w_hdr_d     = r_hdr;
    w_x_d       = r_x;
    w_y_d       = r_y;
    w_addr_d    = r_addr;
    w_we_d      = 1'b0;
    w_fb_addr_d = r_fb_addr;
    w_wdata_d   = r_wdata;
    w_done_d    = r_done;
    w_ovf_d     = r_ovf;
    if (i_clear) begin
      w_state_d   = S_INIT;
      w_hdr_d     = '0;
      w_x_d       = '0;
      w_y_d       = '0;
      w_addr_d    = '0;
      w_fb_addr_d = '0;
      w_wdata_d   = '0;
      w_done_d    = 1'b0;
      w_ovf_d     = 1'b0;
    end else begin
      unique case (r_state)
        S_HDR: begin
          if (i_in_en) begin
            w_hdr_d = r_hdr + HW'(1);
            if (r_hdr == HDR_LAST) w_state_d = S_PIX;
          end
        end
        S_PIX: begin
          if (w_pix_valid) begin
            w_we_d      = 1'b1;
            w_fb_addr_d = r_addr;
            w_wdata_d   = w_pix;
            w_addr_d    = r_addr + ADDR_W'(1);
            if (r_x == X_LAST) begin
              w_x_d = '0;
              if (r_y == Y_LAST) begin
                w_y_d     = '0;
                w_addr_d  = '0;
                w_done_d  = 1'b1;
                w_state_d = S_DONE;
              end else begin
                w_y_d = r_y + YW'(1);
              end
            end else begin
              w_x_d = r_x + XW'(1);
            end
          end
        end
        S_DONE: begin
          if (i_in_en) w_ovf_d = 1'b1;
        end
        default: w_state_d = S_INIT;
      endcase
    end
  end

  assign o_fb_we      = r_we;
  assign o_fb_addr    = r_fb_addr;
  assign o_fb_wdata   = r_wdata;
  assign o_cur_x      = r_x;
  assign o_cur_y      = r_y;
  assign o_frame_done = r_done;
  assign o_overflow   = r_ovf;

endmodule

// File: tb/tb_sd_rgb_fb_writer.sv
// Bench for sd_rgb_fb_writer: a 4x2 frame with a 2-byte header checked every cycle
// against a byte-counting reference model, plus a 3x2 header-less instance.
module tb_sd_rgb_fb_writer;

  localparam int W   = 4;
  localparam int H   = 2;
  localparam int HDR = 2;

  logic clk = 1'b0;
  logic rstn;
  logic clear;
  logic en;
  logic [7:0] din;

  logic        fb_we;
  logic [2:0]  fb_addr;
  logic [23:0] fb_wdata;
  logic [1:0]  cur_x;
  logic [0:0]  cur_y;
  logic        frame_done;
  logic        overflow;

  logic        z_en;
  logic [7:0]  z_byte;
  logic        z_clear;
  logic        z_we;
  logic [2:0]  z_addr;
  logic [23:0] z_wd;
  logic [1:0]  z_x;
  logic [0:0]  z_y;
  logic        z_done;
  logic        z_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  sd_rgb_fb_writer #(.IMG_W(W), .IMG_H(H), .HDR_BYTES(HDR), .ADDR_W(3)) u_dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_clear      (clear),
    .i_in_en      (en),
    .i_in_byte    (din),
    .o_fb_we      (fb_we),
    .o_fb_addr    (fb_addr),
    .o_fb_wdata   (fb_wdata),
    .o_cur_x      (cur_x),
    .o_cur_y      (cur_y),
    .o_frame_done (frame_done),
    .o_overflow   (overflow)
  );

  sd_rgb_fb_writer #(.IMG_W(3), .IMG_H(2), .HDR_BYTES(0), .ADDR_W(3)) u_dut0 (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_clear      (z_clear),
    .i_in_en      (z_en),
    .i_in_byte    (z_byte),
    .o_fb_we      (z_we),
    .o_fb_addr    (z_addr),
    .o_fb_wdata   (z_wd),
    .o_cur_x      (z_x),
    .o_cur_y      (z_y),
    .o_frame_done (z_done),
    .o_overflow   (z_ovf)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, got, exp);
    end
  endtask

  // Reference model: counts accepted bytes and written pixels since start of frame.
  int          m_nb;
  int          m_np;
  logic [7:0]  m_buf [3];
  bit          m_we;
  int          m_addr;
  logic [23:0] m_wd;
  bit          m_done;
  bit          m_ovf;

  function automatic void m_reset();
    m_nb = 0; m_np = 0; m_we = 0; m_addr = 0; m_wd = '0; m_done = 0; m_ovf = 0;
  endfunction

  always @(negedge rstn) m_reset();

  always @(posedge clk) begin
    int k;
    if (!rstn || clear) begin
      m_reset();
    end else begin
      m_we = 0;
      if (en) begin
        if (m_done) begin
          m_ovf = 1;
        end else if (m_nb < HDR) begin
          m_nb++;
        end else begin
          k = (m_nb - HDR) % 3;
          m_buf[k] = din;
          m_nb++;
          if (k == 2) begin
            m_we   = 1;
            m_addr = m_np;
            m_wd   = {m_buf[0], m_buf[1], m_buf[2]};
            m_np++;
            if (m_np == W * H) m_done = 1;
          end
        end
      end
    end
  end

  // Compare every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("fb_we", 32'(fb_we), 32'(m_we));
      chk("fb_addr", 32'(fb_addr), 32'(m_addr));
      chk("fb_wdata", 32'(fb_wdata), 32'(m_wd));
      chk("cur_x", 32'(cur_x), m_done ? 0 : 32'(m_np % W));
      chk("cur_y", 32'(cur_y), m_done ? 0 : 32'(m_np / W));
      chk("frame_done", 32'(frame_done), 32'(m_done));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  // Write logs for literal end-of-scenario checks.
  int          q_addr [$];
  logic [23:0] q_data [$];
  int          z_n = 0;
  int          z_last = -1;
  logic [23:0] z_first = '0;

  always @(negedge clk) begin
    if (rstn && fb_we) begin
      q_addr.push_back(int'(fb_addr));
      q_data.push_back(fb_wdata);
    end
    if (rstn && z_we) begin
      if (z_n == 0) z_first = z_wd;
      z_last = int'(z_addr);
      z_n++;
    end
  end

  task automatic drive(input logic e, input logic [7:0] b, input logic c);
    @(negedge clk);
    en = e; din = b; clear = c;
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic restart();
    drive(1'b0, 8'h00, 1'b1);
    idle(2);
    q_addr.delete();
    q_data.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    m_reset();
    rstn = 1'b0; clear = 1'b0; en = 1'b0; din = '0;
    z_en = 1'b0; z_byte = '0; z_clear = 1'b0;
    #12;
    chk("reset_we", 32'(fb_we), 0);
    chk("reset_x", 32'(cur_x), 0);
    chk("reset_done", 32'(frame_done), 0);
    #10 rstn = 1'b1;
    chk_on = 1'b1;

    // Header plus frame, consecutive bytes.
    send(8'hAA); send(8'hBB);
    for (int i = 0; i < 24; i++) send(8'(i));
    idle(3);
    chk("hf_count", 32'(q_addr.size()), 8);
    if (q_addr.size() == 8) begin
      chk("hf_addr0", 32'(q_addr[0]), 0);
      chk("hf_data0", 32'(q_data[0]), 32'h000102);
      chk("hf_addr7", 32'(q_addr[7]), 7);
      chk("hf_data7", 32'(q_data[7]), 32'h151617);
    end
    chk("hf_done", 32'(frame_done), 1);

    // Gapped input.
    restart();
    send(8'hAA); idle($urandom_range(0, 5));
    send(8'hBB); idle($urandom_range(0, 5));
    for (int i = 0; i < 24; i++) begin
      send(8'(i));
      idle($urandom_range(0, 5));
    end
    idle(2);
    chk("gap_count", 32'(q_addr.size()), 8);
    if (q_addr.size() == 8) chk("gap_data4", 32'(q_data[4]), 32'h0c0d0e);

    // Overflow after frame done.
    for (int i = 0; i < 5; i++) send(8'hE0 + 8'(i));
    idle(2);
    chk("ovf_count", 32'(q_addr.size()), 8);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_done", 32'(frame_done), 1);

    // Clear coincident with the third byte of the first pixel.
    restart();
    send(8'hAA); send(8'hBB); send(8'h10); send(8'h11);
    drive(1'b1, 8'h12, 1'b1);
    send(8'hAA); send(8'hBB); send(8'h20); send(8'h21); send(8'h22);
    idle(3);
    chk("clr_count", 32'(q_addr.size()), 1);
    if (q_addr.size() == 1) begin
      chk("clr_addr", 32'(q_addr[0]), 0);
      chk("clr_data", 32'(q_data[0]), 32'h202122);
    end

    // Randomized streams with occasional clears.
    for (int r = 0; r < 4; r++) begin
      restart();
      for (int i = 0; i < 20 + int'($urandom_range(0, 20)); i++) begin
        drive(1'b1, 8'($urandom), ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        idle($urandom_range(0, 3));
      end
      idle(3);
    end

    // Short file: three pixels plus a trailing byte, never completes.
    restart();
    send(8'hAA); send(8'hBB);
    for (int i = 0; i < 10; i++) send(8'h40 + 8'(i));
    idle(4);
    chk("short_count", 32'(q_addr.size()), 3);
    chk("short_done", 32'(frame_done), 0);
    chk("short_x", 32'(cur_x), 3);

    // Asynchronous reset between edges.
    #2 rstn = 1'b0;
    #1;
    chk("arst_x", 32'(cur_x), 0);
    chk("arst_wdata", 32'(fb_wdata), 0);
    chk("arst_addr", 32'(fb_addr), 0);
    @(negedge clk);
    rstn = 1'b1;
    q_addr.delete();
    q_data.delete();
    send(8'hAA); send(8'hBB); send(8'h30); send(8'h31); send(8'h32);
    idle(3);
    chk("arst_count", 32'(q_addr.size()), 1);
    if (q_addr.size() == 1) begin
      chk("arst_re_addr", 32'(q_addr[0]), 0);
      chk("arst_re_data", 32'(q_data[0]), 32'h303132);
    end

    // Header-less 3x2 instance: 18 bytes make 6 writes.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      z_en = 1'b1; z_byte = 8'(i);
    end
    @(negedge clk);
    z_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("z_count", 32'(z_n), 6);
    chk("z_first", 32'(z_first), 32'h000102);
    chk("z_last", 32'(z_last), 5);
    chk("z_done", 32'(z_done), 1);
    chk("z_ovf", 32'(z_ovf), 0);
    chk("z_xy", 32'({z_x, z_y}), 0);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_rgb_fb_writer.md
Name: sd_rgb_fb_writer

Overview:
- Sits directly downstream of sd_spi_file_reader.
- Consumes its outen/outbyte byte stream (raw .RGB file, bytes ordered R,G,B per pixel, row-major) and optionally skips a fixed header.
- Packs every 3 bytes into a 24-bit pixel and issues one write per pixel to port A of the frame-buffer BRAM at a linear address.
- Reports frame completion and overrun to the status LEDs and the display side.

Parameters:
- IMG_W, 320, pixels per row.
- IMG_H, 240, rows per frame.
- HDR_BYTES, 0, leading file bytes discarded before pixel data.
- ADDR_W, 17, frame-buffer address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  input  1  system clock (50 MHz domain of the file reader).
- rstn  input  1  asynchronous active-low reset.
- clear  input  1  synchronous restart: discard partial pixel, return to start of frame, clear flags.
- in_en  input  1  byte strobe (from outen); one byte per high cycle, may be high on consecutive cycles.
- in_byte  input  8  file byte (from outbyte).
- fb_we  output  1  frame-buffer write enable, single-cycle pulse per pixel.
- fb_addr  output  ADDR_W  pixel address = y*IMG_W + x.
- fb_wdata  output  24  pixel {R[23:16],G[15:8],B[7:0]}.
- cur_x  output  $clog2(IMG_W)  column of the next pixel to be written.
- cur_y  output  $clog2(IMG_H)  row of the next pixel to be written.
- frame_done  output  1  sticky: last pixel of frame written.
- overflow  output  1  sticky: byte received while in S_DONE.

Behaviour:
- Reset (async, rstn=0):
  - All outputs 0; phase=0, hdr_cnt=0, x=y=0.
  - State = S_HDR if HDR_BYTES>0, else S_PIX.
  - Takes effect immediately mid-frame; partial pixel lost.
- States:
  - S_HDR:
    - Each in_en increments hdr_cnt.
    - On the byte where hdr_cnt==HDR_BYTES-1: go to S_PIX.
    - Header bytes never produce writes.
  - S_PIX:
    - in_en with phase 0/1/2 latches the byte into R/G/B; phase wraps 2->0.
    - On phase 2: next cycle fb_we=1, fb_addr=current linear address, fb_wdata = assembled pixel (1-cycle latency from third byte).
    - x increments on each pixel write; at x==IMG_W-1, x wraps to 0 and y increments.
    - Address is a running counter incremented per write; no multiplier.
    - On the write of pixel (IMG_W-1, IMG_H-1): go to S_DONE and set frame_done in the same cycle as that fb_we.
  - S_DONE:
    - in_en is ignored for writing and sets overflow.
    - cur_x/cur_y hold 0/0 after the final write wrap. Address counter wraps to 0.
    - Stays in S_DONE until clear or reset.
- Back-to-back bytes: a pixel completes at most every 3 cycles, so fb_we never needs to stall and no input backpressure exists.
- clear:
  - Same effect as reset, but synchronous and on the next edge.
  - If clear and in_en occur in the same cycle, clear wins and the byte is dropped.
  - A pending fb_we from the previous cycle still completes.
- fb_wdata/fb_addr hold their last values when fb_we=0.
- A file shorter than a frame leaves frame_done=0 indefinitely; trailing bytes (<3) stay unwritten.

Decomposition:
- Package sd_fb_pkg:
  - typedef enum logic[1:0] {S_HDR, S_PIX, S_DONE} fbw_state_t.
  - typedef struct packed {logic[7:0] r,g,b;} rgb_t.
  - Default IMG_W/IMG_H/ADDR_W localparams, shared with the display read-side.
- Optional sub-module sd_rgb_assembler: phase counter plus 3 byte registers, outputs pix_valid/pix. The top keeps the FSM, header skip, x/y and address counters.

Test Plan (small config IMG_W=4, IMG_H=2, HDR_BYTES=2 unless noted):
- Header plus frame:
  - Stimulus: bytes AA,BB then 24 bytes 00..17 on consecutive cycles.
  - Response: 8 fb_we pulses at addr 0..7, data 000102,030405,...,151617.
  - frame_done rises with the 8th pulse; no write for AA/BB.
- Gapped input:
  - Stimulus: same 26 bytes with random 0-5 idle cycles between strobes.
  - Response: identical write sequence, each fb_we exactly 1 cycle after a pixel's third byte.
  - cur_x/cur_y step 0,0->1,0->...->3,0->0,1.
- Overflow:
  - Stimulus: after frame_done, send 5 more bytes.
  - Response: no fb_we; overflow=1; frame_done stays 1.
- Clear mid-pixel:
  - Stimulus: send AA,BB,10,11, assert clear coincident with byte 12, then AA,BB,20,21,22.
  - Response: the 10/11/12 pixel is never written; first write is addr 0, data 202122.
- Async reset mid-frame:
  - Stimulus: drop rstn between cycle edges after 3 pixels written.
  - Response: outputs 0 immediately without a clock edge; the subsequent stream restarts at addr 0.
- Default params, HDR_BYTES=0:
  - Stimulus: 230400 incrementing bytes.
  - Response: 76800 writes, last at addr 76799.
  - frame_done=1, overflow=0.
